// File: rtl/digest_reader.sv
// digest_reader: snapshots SHA-256 H0-H7 on the final-block accumulate and streams them out.
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   Block, acc_done    block index and accumulate strobe; capture on acc_done with Block == 2
//   h_in               {H0..H7}, H0 in the top word
//   out_data/out_valid/out_ready/out_last/out_idx   word stream, H0 first, last on H7
//   hit                H0 has ZBITS leading zeros (captured digest only)
//   busy               a captured digest is still draining
//   overrun            sticky: a capture request arrived while busy
module digest_reader #(
    parameter int ZBITS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   Block,
    input  logic         acc_done,
    input  logic [255:0] h_in,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [2:0]   out_idx,
    output logic         hit,
    output logic         busy,
    output logic         overrun
);
    typedef enum logic {IDLE, SEND} state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [0:7][31:0] words_q, words_d;
    logic            cap_q, cap_d;
    logic            ovr_q, ovr_d;
    logic            req;

    always_comb begin
        req     = acc_done && (Block == 2'd2);
        state_d = state_q;
        idx_d   = idx_q;
        words_d = words_q;
        cap_d   = cap_q;
        // Any request while streaming is dropped, including on the final accept cycle.
        ovr_d   = ovr_q | (req && state_q == SEND);
        if (state_q == IDLE) begin
            if (req) begin
                state_d = SEND;
                idx_d   = 3'd0;
                words_d = h_in;
                cap_d   = 1'b1;
            end
        end else if (out_ready) begin
            state_d = (idx_q == 3'd7) ? IDLE : SEND;
            idx_d   = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            words_q <= '0;
            cap_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            cap_q   <= cap_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy      = (state_q == SEND);
    assign out_valid = busy;
    assign out_data  = busy ? words_q[idx_q] : 32'd0;
    assign out_idx   = idx_q;
    assign out_last  = busy && (idx_q == 3'd7);
    assign overrun   = ovr_q;
    // cap_q keeps hit low after reset, when the zeroed buffer would otherwise read as a hit.
    assign hit       = cap_q && ((words_q[0] >> (32 - ZBITS)) == 32'd0);
endmodule

// File: doc/digest_reader.md
# digest_reader

Output-side reader for the SHA-256 hash registers H0–H7. On the final-block accumulate strobe it snapshots all eight 32-bit hash words and evaluates a difficulty check on H0. It then streams the words out one per handshake over a valid/ready interface, with a last marker, to the result/UART stage. It sits between the H0–H7 accumulator bank and the nonce-result path of the miner.

## Interface
- `ZBITS`, default 32: number of leading zero bits required in H0 for `hit`. Legal range 1..32.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Block` in 2: block index driven to the H registers. 0 = init, 1 = first block, 2 = second/final block. 3 is unused.
- `acc_done` in 1: one-cycle strobe; the H registers finished accumulating for the current `Block`.
- `h_in` in 256: {H0,H1,…,H7}, with H0 in bits [255:224].
- `out_data` out 32: current digest word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the word on any cycle where `out_valid` and `out_ready` are both high.
- `out_last` out 1: high while word 7 is presented.
- `out_idx` out 3: index of the word presented.
- `hit` out 1: H0[31:32-ZBITS] == 0 for the captured digest. Held until the next capture.
- `busy` out 1: a digest is captured and not yet fully drained.
- `overrun` out 1: sticky. A capture request arrived while busy.

## Operation
- A capture request is `acc_done` high while `Block == 2`. `acc_done` with `Block` 0, 1 or 3 is ignored.
- States:
  - IDLE: `out_valid` = 0, `busy` = 0. On a capture request, latch `h_in` into an 8×32 buffer, compute `hit` from `h_in[255:224]`, set `idx` = 0, and go to SEND.
  - SEND: `out_valid` = 1, `out_data` = buffer[idx], `out_idx` = idx, `out_last` = (idx == 7).
    - On a handshake with idx < 7: idx increments.
    - On a handshake with idx == 7: go to IDLE.
    - While `out_ready` is low, all outputs stay stable.
- A capture request in SEND does not modify the buffer, idx or `hit`. It sets `overrun` = 1, and the digest is dropped.
- `overrun` clears only on reset.
- Capture request in the same cycle as the final handshake (idx == 7): the FSM returns to IDLE, the request counts as an overrun, and the digest is dropped. There is no capture-through.
- `hit` is combinational from the captured H0 register only. It never reflects live `h_in`.
- Word order on the stream is H0 first, H7 last. No byte swapping.

## Timing
- All state changes on the rising edge of `clk`. `rst_n` low clears immediately, independent of `clk`.
- Reset values:
  - state = IDLE, idx = 0
  - `out_valid`, `out_last`, `busy`, `hit`, `overrun` = 0
  - `out_data` = 0, `out_idx` = 0, buffer = 0
- Latency: capture request sampled at edge N gives `out_valid` = 1 and `out_data` = H0 after edge N, i.e. in cycle N+1.
- Throughput: with `out_ready` held high, one word per cycle. `out_valid` drops the cycle after word 7 is accepted. Total 8 cycles from the first valid to the last accept.
- Back-to-back: the earliest accepted next capture is the cycle after the return to IDLE.
- Reset during SEND aborts the stream. `out_valid` falls asynchronously, and no partial resume occurs after `rst_n` rises.
- `busy` equals (state == SEND).

## Test plan
- Reset then single digest:
  - Stimulus: `h_in` = {32'h00000000, 32'h11111111, …, 32'h77777777}, `Block` = 2, one `acc_done` strobe, `out_ready` = 1.
  - Required: 8 words 0x0,0x11111111…0x77777777 in consecutive cycles starting one cycle after the strobe. `out_last` only on the 8th word. `hit` = 1 with ZBITS = 32.
- Ignored strobes:
  - Stimulus: `acc_done` with `Block` = 0, then with `Block` = 1.
  - Required: `out_valid` stays 0 and `busy` stays 0.
- Backpressure:
  - Stimulus: `out_ready` low for 3 cycles at idx = 2.
  - Required: `out_data` holds H2 and `out_idx` holds 2 while stalled. The stream resumes at H3 with no loss or duplication.
- Overrun:
  - Stimulus: a second strobe with a different `h_in` at idx = 4.
  - Required: the remaining words come from the first digest, and `overrun` = 1 sticky.
  - Stimulus: a strobe on the idx = 7 accept cycle.
  - Required: also an overrun, and no new stream starts.
- Difficulty check:
  - Stimulus: ZBITS = 8 with H0 = 32'h00FFFFFF.
  - Required: `hit` = 1.
  - Stimulus: ZBITS = 8 with H0 = 32'h01000000.
  - Required: `hit` = 0.
- Async reset mid-stream:
  - Stimulus: assert `rst_n` low at idx = 5, between clock edges.
  - Required: all outputs go to their reset values immediately. After release, the next strobe produces a fresh stream starting at H0.
